instruction_fetch_unit: RTL and testbench

Initiator side of the instruction memory read interface. Drives a 64-bit byte address, waits a fixed number of cycles for the read data to settle, and captures 32-bit instruction words into a small FIFO. The FIFO presents them to decode through a valid/ready handshake. Branch redirects flush all prefetched state and restart fetch at a new PC.

---
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch bus: memory read side (Address/Data) and decode side (Instr* handshake).
// Ports: master = fetch unit (drives Address and the instruction stream, receives Data,
//        Redirect/RedirectPC and InstrReady); slave = memory plus decode environment.
interface instruction_fetch_unit_if #(
  parameter int BUF_DEPTH = 2
);
  logic [63:0]                  Address;
  logic [31:0]                  Data;
  logic                         Redirect;
  logic [63:0]                  RedirectPC;
  logic                         InstrValid;
  logic                         InstrReady;
  logic [31:0]                  Instr;
  logic [63:0]                  InstrPC;
  logic [$clog2(BUF_DEPTH):0]   BufCount;

  modport master (
    output Address, InstrValid, Instr, InstrPC, BufCount,
    input  Data, Redirect, RedirectPC, InstrReady
  );

  modport slave (
    input  Address, InstrValid, Instr, InstrPC, BufCount,
    output Data, Redirect, RedirectPC, InstrReady
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: holds Address for MEM_WAIT cycles, captures Data into a small FIFO, and
// presents words to decode. First word is valid MEM_WAIT+1 cycles after reset/redirect.
// Backpressure: a full FIFO parks the fetch in HOLD with Address frozen until a slot frees.
// Ports: CLK, resetl (sync, active low), ifu (master modport of instruction_fetch_unit_if).
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_WAIT  = 2,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                      CLK,
  input  logic                      resetl,
  instruction_fetch_unit_if.master  ifu
);
  localparam int         PW        = $clog2(BUF_DEPTH);
  localparam int         CW        = PW + 1;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  typedef enum logic {ST_WAIT, ST_HOLD} state_t;

  state_t          state, state_next;
  logic [3:0]      wait_cnt, wait_cnt_next;
  logic [63:0]     fetch_pc;
  logic [31:0]     instr_mem [BUF_DEPTH];
  logic [63:0]     pc_mem    [BUF_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            valid;
  logic            pop;
  logic            space;
  logic            attempt;
  logic            push;

  assign valid = (count != '0);
  assign pop   = valid && ifu.InstrReady;
  // A slot freed by a same-cycle pop can take the new word.
  assign space = (count < CW'(BUF_DEPTH)) || pop;

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state    <= ST_WAIT;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    attempt       = 1'b0;
    push          = 1'b0;
    case (state)
      ST_WAIT: attempt = (wait_cnt == WAIT_LAST);
      ST_HOLD: attempt = 1'b1;   // data already settled, only waiting for a slot
      default: attempt = 1'b0;
    endcase
    if (ifu.Redirect) begin
      // Any capture due this cycle belongs to the abandoned path.
      state_next    = ST_WAIT;
      wait_cnt_next = '0;
    end else if (attempt) begin
      if (space) begin
        push          = 1'b1;
        state_next    = ST_WAIT;
        wait_cnt_next = '0;
      end else begin
        state_next    = ST_HOLD;  // counter stays saturated at WAIT_LAST
      end
    end else begin
      wait_cnt_next = wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (ifu.Redirect) begin
      fetch_pc <= ifu.RedirectPC & ~64'h3;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 64'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked to zero while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (resetl && !ifu.Redirect && push) begin
      instr_mem[wr_ptr] <= ifu.Data;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  assign ifu.Address    = fetch_pc;
  assign ifu.InstrValid = valid;
  assign ifu.Instr      = valid ? instr_mem[rd_ptr] : 32'h0;
  assign ifu.InstrPC    = valid ? pc_mem[rd_ptr] : 64'h0;
  assign ifu.BufCount   = count;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic against a queue model.
// Ports: drives both DUT instances through instruction_fetch_unit_if; clk is shared.
module tb_instruction_fetch_unit;
  localparam int          DEPTH = 2;
  localparam int          MW    = 2;
  localparam logic [63:0] RPC0  = 64'h0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n;
  logic rst1_n;
  int   checks = 0;
  int   errors = 0;

  // Model state for dut0
  ent_t        mq[$];
  logic [63:0] npc;
  int          elapsed;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    case (a)
      64'h0:   mem_word = 32'hf84003e9;
      64'h4:   mem_word = 32'hf84083ea;
      64'h8:   mem_word = 32'hf84103eb;
      64'h2C:  mem_word = 32'hf80203ed;
      default: mem_word = a[33:2] ^ a[63:32] ^ 32'h5A5A_1234;
    endcase
  endfunction

  instruction_fetch_unit_if #(.BUF_DEPTH(DEPTH)) bus0 ();
  instruction_fetch_unit_if #(.BUF_DEPTH(DEPTH)) bus1 ();

  assign bus0.Data = mem_word(bus0.Address);
  assign bus1.Data = mem_word(bus1.Address);

  instruction_fetch_unit #(.RESET_PC(RPC0), .MEM_WAIT(MW), .BUF_DEPTH(DEPTH)) dut0 (
    .CLK(clk), .resetl(rst0_n), .ifu(bus0.master)
  );

  instruction_fetch_unit #(.RESET_PC(RPC0), .MEM_WAIT(1), .BUF_DEPTH(DEPTH)) dut1 (
    .CLK(clk), .resetl(rst1_n), .ifu(bus1.master)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock for dut0: advance the model on the edge, then compare every output.
  task automatic cycle0();
    bit pop, space, cap;
    @(posedge clk);
    if (!rst0_n) begin
      mq.delete();
      npc     = RPC0;
      elapsed = 0;
    end else if (bus0.Redirect) begin
      mq.delete();
      npc     = {bus0.RedirectPC[63:2], 2'b00};
      elapsed = 0;
    end else begin
      pop   = (mq.size() > 0) && bus0.InstrReady;
      space = (mq.size() < DEPTH) || pop;
      cap   = (elapsed >= MW - 1) && space;
      if (pop) mq.delete(0);
      if (cap) begin
        mq.push_back('{pc: npc, w: mem_word(npc)});
        npc     = npc + 64'd4;
        elapsed = 0;
      end else begin
        elapsed++;
      end
    end
    #1;
    chk("m_addr",  bus0.Address, npc);
    chk("m_valid", 64'(bus0.InstrValid), 64'(mq.size() > 0));
    chk("m_count", 64'(bus0.BufCount), 64'(mq.size()));
    chk("m_instr", 64'(bus0.Instr), (mq.size() > 0) ? 64'(mq[0].w) : 64'h0);
    chk("m_pc",    bus0.InstrPC, (mq.size() > 0) ? mq[0].pc : 64'h0);
  endtask

  task automatic run0(int n);
    for (int i = 0; i < n; i++) cycle0();
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    bus0.Redirect = 1'b0; bus0.RedirectPC = '0; bus0.InstrReady = 1'b0;
    bus1.Redirect = 1'b0; bus1.RedirectPC = '0; bus1.InstrReady = 1'b0;
    npc = RPC0; elapsed = 0;

    // 1: streaming with decode always ready
    bus0.InstrReady = 1'b1;
    cycle0();
    chk("rst_addr",  bus0.Address, 64'h0);
    chk("rst_valid", 64'(bus0.InstrValid), 64'h0);
    chk("rst_instr", 64'(bus0.Instr), 64'h0);
    chk("rst_pc",    bus0.InstrPC, 64'h0);
    chk("rst_count", 64'(bus0.BufCount), 64'h0);
    rst0_n = 1'b1;
    cycle0();
    chk("t1_valid_c2", 64'(bus0.InstrValid), 64'h0);
    cycle0();
    chk("t1_valid_c3", 64'(bus0.InstrValid), 64'h1);
    chk("t1_instr0", 64'(bus0.Instr), 64'hf84003e9);
    chk("t1_pc0", bus0.InstrPC, 64'h0);
    run0(2);
    chk("t1_instr1", 64'(bus0.Instr), 64'hf84083ea);
    chk("t1_pc1", bus0.InstrPC, 64'h4);
    run0(2);
    chk("t1_instr2", 64'(bus0.Instr), 64'hf84103eb);
    chk("t1_pc2", bus0.InstrPC, 64'h8);

    // 2: fill with decode stalled, then one pop while in HOLD
    rst0_n = 1'b0; bus0.InstrReady = 1'b0;
    cycle0();
    rst0_n = 1'b1;
    run0(8);
    chk("t2_count", 64'(bus0.BufCount), 64'h2);
    chk("t2_head_pc", bus0.InstrPC, 64'h0);
    chk("t2_addr_hold", bus0.Address, 64'h8);
    bus0.InstrReady = 1'b1;
    cycle0();
    bus0.InstrReady = 1'b0;
    chk("t2_count_after", 64'(bus0.BufCount), 64'h2);
    chk("t2_head_after", bus0.InstrPC, 64'h4);
    chk("t2_addr_after", bus0.Address, 64'hC);
    run0(3);
    chk("t2_head_stable", bus0.InstrPC, 64'h4);

    // 3: redirect while full, unaligned target
    bus0.Redirect = 1'b1; bus0.RedirectPC = 64'h2D;
    cycle0();
    bus0.Redirect = 1'b0;
    chk("t3_valid", 64'(bus0.InstrValid), 64'h0);
    chk("t3_count", 64'(bus0.BufCount), 64'h0);
    chk("t3_addr", bus0.Address, 64'h2C);
    run0(2);
    chk("t3_instr", 64'(bus0.Instr), 64'hf80203ed);
    chk("t3_pc", bus0.InstrPC, 64'h2C);

    // 4: redirect on the same edge as a capture and a pop
    run0(3);
    bus0.InstrReady = 1'b1; bus0.Redirect = 1'b1; bus0.RedirectPC = 64'h100;
    cycle0();
    bus0.Redirect = 1'b0;
    chk("t4_count", 64'(bus0.BufCount), 64'h0);
    chk("t4_addr", bus0.Address, 64'h100);
    run0(2);
    chk("t4_pc", bus0.InstrPC, 64'h100);
    // held redirect: restarts every cycle, nothing captured
    bus0.Redirect = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus0.RedirectPC = 64'(i * 'h100 + 5);
      cycle0();
      chk("t4_hold_valid", 64'(bus0.InstrValid), 64'h0);
    end
    bus0.Redirect = 1'b0;
    run0(2);
    chk("t4_resume_pc", bus0.InstrPC, 64'h304);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus0.InstrReady = ($urandom_range(0, 99) < 60);
      bus0.Redirect   = ($urandom_range(0, 29) == 0);
      bus0.RedirectPC = {$urandom, $urandom};
      cycle0();
    end

    // 5: reset overrides redirect and handshake mid-stream
    bus0.Redirect = 1'b0; bus0.InstrReady = 1'b0;
    run0(4);
    rst0_n = 1'b0; bus0.Redirect = 1'b1; bus0.RedirectPC = 64'h8000; bus0.InstrReady = 1'b1;
    cycle0();
    chk("t5_addr",  bus0.Address, 64'h0);
    chk("t5_valid", 64'(bus0.InstrValid), 64'h0);
    chk("t5_instr", 64'(bus0.Instr), 64'h0);
    chk("t5_pc",    bus0.InstrPC, 64'h0);
    chk("t5_count", 64'(bus0.BufCount), 64'h0);
    rst0_n = 1'b1; bus0.Redirect = 1'b0;
    run0(6);

    // 6: MEM_WAIT=1 instance, wrap of the fetch PC
    bus1.InstrReady = 1'b1;
    tick1();
    rst1_n = 1'b1;
    bus1.Redirect = 1'b1; bus1.RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    tick1();
    bus1.Redirect = 1'b0;
    chk("t6_addr", bus1.Address, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_valid0", 64'(bus1.InstrValid), 64'h0);
    tick1();
    chk("t6_pc0", bus1.InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_instr0", 64'(bus1.Instr), 64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
    chk("t6_addr_wrap", bus1.Address, 64'h0);
    tick1();
    chk("t6_pc1", bus1.InstrPC, 64'h0);
    chk("t6_instr1", 64'(bus1.Instr), 64'hf84003e9);
    tick1();
    chk("t6_pc2", bus1.InstrPC, 64'h4);
    chk("t6_valid2", 64'(bus1.InstrValid), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
